bist_controller: RTL and testbench

//  Sequences one LBIST session: seeds and steps the test pattern generator, holds the ORA in

---
 rtl/bist_controller.sv | 178 +++++++++++++++++
 tb/tb_bist_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_controller.sv
// bist_controller: sequences one LBIST session.
// The controller seeds and steps the TPG and holds the ORA in reset during INIT.
// It applies N_PATTERNS patterns, then waits RES_LAT cycles so the last ORA result can land.
// ORA results are sampled through a valid pipe that matches the ORA latency.
// Optional feature macro: BIST_FIRST_FAIL_EN. When it is defined, the controller also
// records the index of the first failing pattern (FIRST_FAIL_IDX / FIRST_FAIL_VLD).
module bist_controller #(
  parameter int N_PATTERNS = 16,
  parameter int PAT_BITS   = 8,
  parameter int RES_LAT    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                START,
  input  logic                RES,
  output logic                TPG_LOAD,
  output logic                TPG_EN,
  output logic                ORA_RST,
  output logic                TEST_MODE,
  output logic                BUSY,
  output logic                DONE,
  output logic                FAIL,
  output logic [PAT_BITS-1:0] FAIL_CNT
`ifdef BIST_FIRST_FAIL_EN
  ,
  output logic [PAT_BITS-1:0] FIRST_FAIL_IDX,
  output logic                FIRST_FAIL_VLD
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int                DW         = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;
  localparam logic [PAT_BITS-1:0] LAST_IDX = PAT_BITS'(N_PATTERNS - 1);
  localparam logic [DW-1:0]     DRAIN_INIT = DW'(RES_LAT - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [PAT_BITS-1:0] r_idx;
  logic [DW-1:0]       r_drain;
  logic [RES_LAT-1:0]  r_vpipe;
  logic                r_fail;
  logic [PAT_BITS-1:0] r_fail_cnt;
  logic                w_start_session;
  logic                w_sample_fail;

  // A new session begins on the edge that moves IDLE/DONE into INIT. All per-session
  // results are cleared on that edge, so FAIL/FAIL_CNT already read zero during INIT.
  assign w_start_session = (w_state_next == S_INIT);
  assign w_sample_fail   = r_vpipe[RES_LAT-1] & RES;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments. The whole block then
    // updates atomically on the edge, and readers in other processes cannot race with it.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic and Moore outputs decoded from the current state.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. A path that leaves a
    // signal unassigned would otherwise infer a latch.
    w_state_next = r_state;
    TPG_LOAD     = 1'b0;
    TPG_EN       = 1'b0;
    ORA_RST      = 1'b0;
    TEST_MODE    = 1'b0;
    BUSY         = 1'b0;
    DONE         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (START) w_state_next = S_INIT;
      end
      S_INIT: begin
        TPG_LOAD     = 1'b1;
        ORA_RST      = 1'b1;
        TEST_MODE    = 1'b1;
        BUSY         = 1'b1;
        w_state_next = S_RUN;
      end
      S_RUN: begin
        TPG_EN    = 1'b1;
        TEST_MODE = 1'b1;
        BUSY      = 1'b1;
        if (r_idx == LAST_IDX) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        TEST_MODE = 1'b1;
        BUSY      = 1'b1;
        if (r_drain == '0) w_state_next = S_DONE;
      end
      S_DONE: begin
        DONE = 1'b1;
        if (START) w_state_next = S_INIT;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Pattern index, drain countdown, result-valid pipe and fail accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_drain    <= '0;
      r_vpipe    <= '0;
      r_fail     <= 1'b0;
      r_fail_cnt <= '0;
    end else begin
      if (w_start_session)      r_idx <= '0;
      else if (r_state == S_RUN) r_idx <= r_idx + 1'b1;

      if (r_state == S_RUN)                         r_drain <= DRAIN_INIT;
      else if (r_state == S_DRAIN && r_drain != '0) r_drain <= r_drain - 1'b1;

      // Each applied pattern (TPG_EN) becomes a valid ORA sample RES_LAT cycles later.
      if (w_start_session) begin
        r_vpipe <= '0;
      end else begin
        r_vpipe[0] <= TPG_EN;
        for (int i = 1; i < RES_LAT; i++) r_vpipe[i] <= r_vpipe[i-1];
      end

      if (w_start_session) begin
        r_fail     <= 1'b0;
        r_fail_cnt <= '0;
      end else if (w_sample_fail) begin
        r_fail <= 1'b1;
        if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
      end
    end
  end

  assign FAIL     = r_fail;
  assign FAIL_CNT = r_fail_cnt;

`ifdef BIST_FIRST_FAIL_EN
  logic [PAT_BITS-1:0] r_ipipe [RES_LAT];
  logic [PAT_BITS-1:0] r_ff_idx;
  logic                r_ff_vld;

  // Index pipe runs beside the valid pipe; the first failing sample captures its pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this small pipe array is reset explicitly, entry by entry. Large storage
      // arrays would normally be left unreset.
      for (int i = 0; i < RES_LAT; i++) r_ipipe[i] <= '0;
      r_ff_idx <= '0;
      r_ff_vld <= 1'b0;
    end else begin
      if (w_start_session) begin
        for (int i = 0; i < RES_LAT; i++) r_ipipe[i] <= '0;
      end else begin
        r_ipipe[0] <= r_idx;
        for (int i = 1; i < RES_LAT; i++) r_ipipe[i] <= r_ipipe[i-1];
      end

      if (w_start_session) begin
        r_ff_idx <= '0;
        r_ff_vld <= 1'b0;
      end else if (w_sample_fail && !r_ff_vld) begin
        r_ff_idx <= r_ipipe[RES_LAT-1];
        r_ff_vld <= 1'b1;
      end
    end
  end

  assign FIRST_FAIL_IDX = r_ff_idx;
  assign FIRST_FAIL_VLD = r_ff_vld;
`endif

endmodule

// File: tb/tb_bist_controller.sv
// tb_bist_controller: scoreboard bench for bist_controller.
// dut0 uses the default parameters. dut1 is a small saturating configuration
// (PAT_BITS=2, N_PATTERNS=4). dut2 uses RES_LAT=3.
// Each session pushes its hand-computed result onto the scoreboard. The monitor pops and
// compares that entry when the DUT raises DONE.
module tb_bist_controller;

  typedef struct {
    int         d;
    logic       fail;
    logic [7:0] cnt;
    int         lat;
    logic [7:0] ffi;
    logic       ffv;
  } exp_t;

  logic clk;
  logic rst;
  logic start_i [3];
  logic res_i   [3];
  logic load_o  [3];
  logic en_o    [3];
  logic ora_o   [3];
  logic tm_o    [3];
  logic busy_o  [3];
  logic done_o  [3];
  logic fail_o  [3];
  logic [7:0] cnt_o [3];
  logic [7:0] cnt0, cnt2;
  logic [1:0] cnt1;
`ifdef BIST_FIRST_FAIL_EN
  logic [7:0] ffi_o [3];
  logic       ffv_o [3];
  logic [7:0] ffi0, ffi2;
  logic [1:0] ffi1;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc [3] = '{-1000, -1000, -1000};
  int n_pat     [3] = '{16, 4, 16};
  int r_lat     [3] = '{1, 1, 3};
  logic [15:0] res_mask [3] = '{16'h0, 16'h0, 16'h0};
  logic        res_out  [3] = '{1'b0, 1'b0, 1'b0};
  int   nload  [3] = '{0, 0, 0};
  int   nen    [3] = '{0, 0, 0};
  logic done_q [3] = '{1'b0, 1'b0, 1'b0};
  int   res_j;
  exp_t mon_e;
  exp_t sb [$];

  bist_controller #(.N_PATTERNS(16), .PAT_BITS(8), .RES_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .START(start_i[0]), .RES(res_i[0]),
    .TPG_LOAD(load_o[0]), .TPG_EN(en_o[0]), .ORA_RST(ora_o[0]), .TEST_MODE(tm_o[0]),
    .BUSY(busy_o[0]), .DONE(done_o[0]), .FAIL(fail_o[0]), .FAIL_CNT(cnt0)
`ifdef BIST_FIRST_FAIL_EN
    , .FIRST_FAIL_IDX(ffi0), .FIRST_FAIL_VLD(ffv_o[0])
`endif
  );

  bist_controller #(.N_PATTERNS(4), .PAT_BITS(2), .RES_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .START(start_i[1]), .RES(res_i[1]),
    .TPG_LOAD(load_o[1]), .TPG_EN(en_o[1]), .ORA_RST(ora_o[1]), .TEST_MODE(tm_o[1]),
    .BUSY(busy_o[1]), .DONE(done_o[1]), .FAIL(fail_o[1]), .FAIL_CNT(cnt1)
`ifdef BIST_FIRST_FAIL_EN
    , .FIRST_FAIL_IDX(ffi1), .FIRST_FAIL_VLD(ffv_o[1])
`endif
  );

  bist_controller #(.N_PATTERNS(16), .PAT_BITS(8), .RES_LAT(3)) dut2 (
    .clk(clk), .rst(rst), .START(start_i[2]), .RES(res_i[2]),
    .TPG_LOAD(load_o[2]), .TPG_EN(en_o[2]), .ORA_RST(ora_o[2]), .TEST_MODE(tm_o[2]),
    .BUSY(busy_o[2]), .DONE(done_o[2]), .FAIL(fail_o[2]), .FAIL_CNT(cnt2)
`ifdef BIST_FIRST_FAIL_EN
    , .FIRST_FAIL_IDX(ffi2), .FIRST_FAIL_VLD(ffv_o[2])
`endif
  );

  always_comb begin
    cnt_o[0] = cnt0;
    cnt_o[1] = {6'b0, cnt1};
    cnt_o[2] = cnt2;
`ifdef BIST_FIRST_FAIL_EN
    ffi_o[0] = ffi0;
    ffi_o[1] = {6'b0, ffi1};
    ffi_o[2] = ffi2;
`endif
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs(input int d);
    return {load_o[d], en_o[d], ora_o[d], tm_o[d], busy_o[d], done_o[d], fail_o[d]};
  endfunction

  // RES driver. Pattern k's ORA result is presented in the cycle after edge 1+k+RES_LAT,
  // counted from the edge that sampled START. Outside that window RES takes res_out.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      res_j = cyc - start_cyc[d];
      if (res_j >= 1 + r_lat[d] && res_j <= n_pat[d] + r_lat[d])
        res_i[d] = res_mask[d][res_j - 1 - r_lat[d]];
      else
        res_i[d] = res_out[d];
    end
  end

  // Monitor: counts strobes per session and checks the scoreboard entry on each DONE rise.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        nload[d]  = 0;
        nen[d]    = 0;
        done_q[d] = 1'b0;
      end else begin
        if (load_o[d]) nload[d]++;
        if (en_o[d])   nen[d]++;
        if (done_o[d] && !done_q[d]) begin
          if (sb.size() == 0) begin
            check($sformatf("d%0d_done_expected", d), 0, 1);
          end else begin
            mon_e = sb.pop_front();
            check($sformatf("d%0d_sb_dut", d), d, mon_e.d);
            check($sformatf("d%0d_fail", d), fail_o[d], mon_e.fail);
            check($sformatf("d%0d_fail_cnt", d), cnt_o[d], mon_e.cnt);
            check($sformatf("d%0d_latency", d), cyc - start_cyc[d], mon_e.lat);
            check($sformatf("d%0d_tpg_en_cycles", d), nen[d], n_pat[d]);
            check($sformatf("d%0d_tpg_load_cycles", d), nload[d], 1);
`ifdef BIST_FIRST_FAIL_EN
            check($sformatf("d%0d_first_idx", d), ffi_o[d], mon_e.ffi);
            check($sformatf("d%0d_first_vld", d), ffv_o[d], mon_e.ffv);
`endif
          end
          nload[d] = 0;
          nen[d]   = 0;
        end
        done_q[d] = done_o[d];
      end
    end
  end

  task automatic run_session(input int d, input logic [15:0] mask, input logic outside,
                             input int hold, input logic efail, input logic [7:0] ecnt,
                             input int elat, input logic [7:0] effi, input logic effv);
    exp_t e;
    int   k;
    @(negedge clk);
    res_mask[d] = mask;
    res_out[d]  = outside;
    e.d = d; e.fail = efail; e.cnt = ecnt; e.lat = elat; e.ffi = effi; e.ffv = effv;
    sb.push_back(e);
    start_i[d] = 1'b1;
    @(posedge clk);
    #1;
    start_cyc[d] = cyc;
    if (hold == 0) start_i[d] = 1'b0;
    check($sformatf("d%0d_init_outs", d), outs(d) >> 1, 6'b101110);
    @(posedge clk);
    #1;
    check($sformatf("d%0d_run0_outs", d), outs(d), 7'b0101100);
    check($sformatf("d%0d_run0_cnt", d), cnt_o[d], 0);
    if (hold > 1) repeat (hold - 1) @(posedge clk);
    @(negedge clk);
    start_i[d] = 1'b0;
    k = 0;
    while (k < 200 && !done_o[d]) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("d%0d_done_reached", d), done_o[d], 1);
    repeat (4) @(negedge clk);
    check($sformatf("d%0d_done_hold_outs", d), outs(d), {6'b000001, efail});
    check($sformatf("d%0d_done_hold_cnt", d), cnt_o[d], ecnt);
    res_mask[d] = 16'h0;
    res_out[d]  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) start_i[d] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d_reset_outs", d), outs(d), 0);
      check($sformatf("d%0d_reset_cnt", d), cnt_o[d], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Default configuration: pass run, fault on patterns 3 and 9, START held through RUN,
    // RES high only where it must be masked, then a new session after a fault clears the results.
    run_session(0, 16'h0000, 1'b0, 0,  1'b0, 8'd0, 18, 8'd0, 1'b0);
    run_session(0, 16'h0208, 1'b0, 0,  1'b1, 8'd2, 18, 8'd3, 1'b1);
    run_session(0, 16'h0000, 1'b0, 17, 1'b0, 8'd0, 18, 8'd0, 1'b0);
    run_session(0, 16'h0000, 1'b1, 0,  1'b0, 8'd0, 18, 8'd0, 1'b0);
    run_session(0, 16'h0208, 1'b0, 0,  1'b1, 8'd2, 18, 8'd3, 1'b1);
    run_session(0, 16'h0000, 1'b0, 0,  1'b0, 8'd0, 18, 8'd0, 1'b0);

    // Reset during pattern 5 after patterns 0 and 1 failed.
    @(negedge clk);
    res_mask[0] = 16'h0003;
    start_i[0]  = 1'b1;
    @(posedge clk);
    #1;
    start_cyc[0] = cyc;
    start_i[0]   = 1'b0;
    while ((cyc - start_cyc[0]) < 6) @(negedge clk);
    check("d0_pre_reset_en", en_o[0], 1);
    check("d0_pre_reset_cnt", cnt_o[0], 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("d0_midrun_reset_outs", outs(0), 0);
    check("d0_midrun_reset_cnt", cnt_o[0], 0);
    start_cyc[0] = -1000;
    res_mask[0]  = 16'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("d0_no_partial_done", done_o[0], 0);
    run_session(0, 16'h0000, 1'b0, 0, 1'b0, 8'd0, 18, 8'd0, 1'b0);

    // Saturation: RES high for the whole session on the 2-bit counter.
    run_session(1, 16'h000F, 1'b1, 0, 1'b1, 8'd3, 6, 8'd0, 1'b1);

    // RES_LAT=3: pass run, masking (includes the ORA reset-recovery window), fault run.
    run_session(2, 16'h0000, 1'b0, 0, 1'b0, 8'd0, 20, 8'd0, 1'b0);
    run_session(2, 16'h0000, 1'b1, 0, 1'b0, 8'd0, 20, 8'd0, 1'b0);
    run_session(2, 16'h0208, 1'b0, 0, 1'b1, 8'd2, 20, 8'd3, 1'b1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
